// File: rtl/instruction_ram_loader_pkg.sv
// Shared types and constants for the instruction RAM loader.
//   loader_state_t  : loader FSM encoding
//   BYTES_PER_WORD  : bytes packed into one 32-bit instruction word
//   IDX_W           : width of the byte-lane index
package instr_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/instruction_ram_loader_if.sv
// Byte-stream valid/ready interface feeding the instruction RAM loader.
//   in_valid : source has a byte
//   in_ready : loader accepts the byte (transfer = in_valid & in_ready)
//   in_data  : image byte
//   in_last  : marks the final byte of the image
// Modports: master = byte source, slave = loader.
interface instruction_ram_loader_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/instruction_ram_loader_packer.sv
// instr_byte_packer: collects bytes little-endian into a 32-bit word.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : store byte_i at the current lane and advance the lane index
//   clear_i     : reset lane index and word (takes priority over load_i)
//   byte_i      : incoming byte
//   word_o      : stored lanes with byte_i merged at the current lane, so the
//                 complete word is visible in the same cycle the last byte arrives
//   word_full_o : current lane is the last one of the word
module instr_byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [IDX_W-1:0] idx_q;
    logic [31:0]      word_q;
    logic [31:0]      word_d;

    always_comb begin
        word_d               = word_q;
        word_d[8*idx_q +: 8] = byte_i;
    end

    assign word_o      = word_d;
    assign word_full_o = (idx_q == IDX_W'(BYTES_PER_WORD - 1));

    // Index wraps to 0 after the last lane, ready for the next word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (load_i) begin
            idx_q  <= idx_q + IDX_W'(1);
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instruction_ram_loader.sv
// instruction_ram_loader: loads a byte stream into instruction RAM as 32-bit
// little-endian words at consecutive addresses from 0, holding the CPU in reset
// until a complete image has been written.
//   clk, rst_n     : clock, async active-low reset
//   start_i        : one-cycle pulse starting a new load (IDLE/DONE/ERR only)
//   in_if          : byte stream (slave modport)
//   mem_we_o       : RAM write enable (one cycle per word)
//   mem_wa_o       : RAM word address (held when mem_we_o = 0)
//   mem_wd_o       : RAM write data (held when mem_we_o = 0)
//   cpu_rst_n_o    : CPU reset, 0 = held in reset
//   done_o, err_o  : load complete / load failed (levels)
//   words_loaded_o : words written by the current or last load
// Optional build macro INSTR_LOADER_CHECKSUM_EN adds csum_o, the XOR of all
// words written since the last start.
module instruction_ram_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned SIZE   = 64,
    parameter int unsigned ADDR_W = $clog2(SIZE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    instruction_ram_loader_if.slave  in_if,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_wa_o,
    output logic [31:0]              mem_wd_o,
    output logic                     cpu_rst_n_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [ADDR_W:0]          words_loaded_o
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]              csum_o
`endif
);

    loader_state_t     state_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_wa_q;
    logic [31:0]       mem_wd_q;
    logic              cpu_rst_n_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W-1:0] addr_q;
    logic              last_q;

    logic              xfer;
    logic              start_ok;
    logic [31:0]       pk_word;
    logic              pk_full;

    assign xfer     = in_if.in_valid & in_ready_q;
    assign start_ok = start_i & (state_q inside {IDLE, DONE, ERR});

    instr_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (xfer),
        .clear_i     (start_ok),
        .byte_i      (in_if.in_data),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wa_q    <= '0;
            mem_wd_q    <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
            addr_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_i) begin
                        state_q     <= RECV;
                        in_ready_q  <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                        addr_q      <= '0;
                        words_q     <= '0;
                    end
                end
                RECV: begin
                    if (xfer) begin
                        if (pk_full) begin
                            // Present the finished word to the RAM during WRITE.
                            state_q    <= WRITE;
                            in_ready_q <= 1'b0;
                            mem_we_q   <= 1'b1;
                            mem_wa_q   <= addr_q;
                            mem_wd_q   <= pk_word;
                            last_q     <= in_if.in_last;
                        end else if (in_if.in_last) begin
                            // Image length not a whole number of words: drop the partial.
                            state_q    <= ERR;
                            in_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    words_q <= words_q + (ADDR_W + 1)'(1);
                    if (last_q) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        cpu_rst_n_q <= 1'b1;
                    end else if (addr_q == ADDR_W'(SIZE - 1)) begin
                        // RAM full but image continues: overflow, never wrap.
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        state_q    <= RECV;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign mem_we_o       = mem_we_q;
    assign mem_wa_o       = mem_wa_q;
    assign mem_wd_o       = mem_wd_q;
    assign cpu_rst_n_o    = cpu_rst_n_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_q;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;

    // Folds in the word being written, on the same edge words_loaded advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (state_q == WRITE) begin
            csum_q <= csum_q ^ mem_wd_q;
        end
    end

    assign csum_o = csum_q;
`endif

endmodule

// File: tb/tb_instruction_ram_loader.sv
module tb_instruction_ram_loader;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start0  = 1'b0;
    logic start_s = 1'b0;

    always #5 clk = ~clk;

    instruction_ram_loader_if if0 ();
    instruction_ram_loader_if if_s ();

    logic        we0, cpu0, done0, err0;
    logic [5:0]  wa0;
    logic [31:0] wd0;
    logic [6:0]  words0;
    logic        wes, cpu_s, done_s, err_s;
    logic [1:0]  was;
    logic [31:0] wds;
    logic [2:0]  words_s;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] csum0, csum_s;
`endif

    instruction_ram_loader #(.SIZE(64)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start0),
        .in_if          (if0),
        .mem_we_o       (we0),
        .mem_wa_o       (wa0),
        .mem_wd_o       (wd0),
        .cpu_rst_n_o    (cpu0),
        .done_o         (done0),
        .err_o          (err0),
        .words_loaded_o (words0)
`ifdef INSTR_LOADER_CHECKSUM_EN
        ,
        .csum_o         (csum0)
`endif
    );

    instruction_ram_loader #(.SIZE(4)) u_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_s),
        .in_if          (if_s),
        .mem_we_o       (wes),
        .mem_wa_o       (was),
        .mem_wd_o       (wds),
        .cpu_rst_n_o    (cpu_s),
        .done_o         (done_s),
        .err_o          (err_s),
        .words_loaded_o (words_s)
`ifdef INSTR_LOADER_CHECKSUM_EN
        ,
        .csum_o         (csum_s)
`endif
    );

    // RAM models and write monitors.
    logic [31:0] ram0 [64];
    logic [31:0] ram_s [4];
    int          wr0       = 0;
    int          wrs       = 0;
    int          rdy_in_wr = 0;
    int          wr_at_s [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        if (we0) begin
            ram0[wa0] <= wd0;
            wr0       <= wr0 + 1;
            if (if0.in_ready) rdy_in_wr <= rdy_in_wr + 1;
        end
        if (wes) begin
            ram_s[was]   <= wds;
            wrs          <= wrs + 1;
            wr_at_s[was] <= wr_at_s[was] + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic l);
        if (sel) begin
            if_s.in_valid = v; if_s.in_data = d; if_s.in_last = l;
        end else begin
            if0.in_valid = v; if0.in_data = d; if0.in_last = l;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? if_s.in_ready : if0.in_ready;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_byte(input bit sel, input logic [7:0] d, input logic l, input bit rnd);
        int budget;
        bit got;
        budget = 0;
        got    = 1'b0;
        if (rnd && $urandom_range(1, 0) == 1) begin
            drive(sel, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
        end
        drive(sel, 1'b1, d, l);
        while (!got && budget < 40) begin
            if (rdy(sel)) got = 1'b1;
            @(negedge clk);
            budget++;
        end
        drive(sel, 1'b0, 8'h00, 1'b0);
        if (!got) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input logic l, input bit rnd);
        for (int b = 0; b < 4; b++) begin
            send_byte(sel, w[8*b +: 8], (b == 3) ? l : 1'b0, rnd);
        end
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_s = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        start0  = 1'b0;
    endtask

    task automatic wait_end0();
        int n;
        n = 0;
        while (!(done0 || err0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(done0 || err0)) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] img [8] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'hDEADBEEF,
                             32'h0040A183, 32'h12345678, 32'hFFFFFFFF, 32'h00008067};
    int base;

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_cpu_rst_n", cpu0, 0);
        check("rst_we", we0, 0);
        check("rst_wa", wa0, 0);
        check("rst_wd", wd0, 0);
        check("rst_words", words0, 0);
        check("rst_ready", if0.in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word image, with write latency and hold checks
        pulse_start(1'b0);
        check("t1_ready_after_start", if0.in_ready, 1);
        send_word(1'b0, 32'h00000013, 1'b0, 1'b0);
        check("t1_we_after_4th", we0, 1);
        check("t1_wa", wa0, 0);
        check("t1_wd", wd0, 32'h00000013);
        check("t1_ready_in_write", if0.in_ready, 0);
        @(negedge clk);
        check("t1_we_drop", we0, 0);
        check("t1_wd_hold", wd0, 32'h00000013);
        check("t1_words_1", words0, 1);
        send_word(1'b0, 32'h00100093, 1'b1, 1'b0);
        wait_end0();
        check("t1_ram0", ram0[0], 32'h00000013);
        check("t1_ram1", ram0[1], 32'h00100093);
        check("t1_done", done0, 1);
        check("t1_err", err0, 0);
        check("t1_cpu_rst_n", cpu0, 1);
        check("t1_words", words0, 2);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("t1_csum", csum0, 32'h00100080);
`endif

        // Eight words with gappy valid; restart from DONE
        pulse_start(1'b0);
        check("t2_done_drop", done0, 0);
        check("t2_cpu_rst_n_drop", cpu0, 0);
        check("t2_words_clr", words0, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("t2_csum_clr", csum0, 32'h0);
`endif
        base = wr0;
        for (int i = 0; i < 8; i++) send_word(1'b0, img[i], (i == 7), 1'b1);
        wait_end0();
        for (int i = 0; i < 8; i++) check($sformatf("t2_ram%0d", i), ram0[i], img[i]);
        check("t2_writes", wr0 - base, 8);
        check("t2_ready_during_write", rdy_in_wr, 0);
        check("t2_words", words0, 8);
        check("t2_done", done0, 1);

        // in_last on the 6th byte: partial word dropped
        pulse_start(1'b0);
        base = wr0;
        send_word(1'b0, 32'hAABBCCDD, 1'b0, 1'b0);
        send_byte(1'b0, 8'h11, 1'b0, 1'b0);
        send_byte(1'b0, 8'h22, 1'b1, 1'b0);
        check("t3_err", err0, 1);
        check("t3_done", done0, 0);
        check("t3_cpu_rst_n", cpu0, 0);
        check("t3_ready", if0.in_ready, 0);
        check("t3_words", words0, 1);
        check("t3_writes", wr0 - base, 1);
        check("t3_ram0", ram0[0], 32'hAABBCCDD);
        check("t3_ram1_untouched", ram0[1], img[1]);

        // Overflow on SIZE=4 instance
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) send_word(1'b1, 32'h11111111 * (i + 1), 1'b0, 1'b0);
        @(negedge clk);
        check("t4_err", err_s, 1);
        check("t4_done", done_s, 0);
        check("t4_cpu_rst_n", cpu_s, 0);
        check("t4_writes", wrs, 4);
        check("t4_words", words_s, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_wr_at%0d", i), wr_at_s[i], 1);
            check($sformatf("t4_ram%0d", i), ram_s[i], 32'h11111111 * (i + 1));
        end
        drive(1'b1, 1'b1, 8'h55, 1'b0);
        repeat (5) @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        check("t4_no_more_writes", wrs, 4);
        check("t4_ready", if_s.in_ready, 0);

        // Asynchronous reset mid-load, then reload from address 0 / lane 0
        pulse_start(1'b0);
        send_word(1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
        send_byte(1'b0, 8'h01, 1'b0, 1'b0);
        send_byte(1'b0, 8'h02, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_we", we0, 0);
        check("t5_wd", wd0, 0);
        check("t5_words", words0, 0);
        check("t5_ready", if0.in_ready, 0);
        check("t5_cpu_rst_n", cpu0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(1'b0);
        send_word(1'b0, 32'h12345678, 1'b1, 1'b0);
        wait_end0();
        check("t5_ram0", ram0[0], 32'h12345678);
        check("t5_words_after", words0, 1);
        check("t5_done", done0, 1);
        check("t5_cpu_rst_n_after", cpu0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
